// File: rtl/multi_line_buffer_pkg.sv
// Shared definitions for the multi-slot line capture buffer: slot state encoding and width helpers.
// The optional per-slot line sum is enabled by MULTI_LINE_BUFFER_LINE_SUM_EN.
package multi_line_buffer_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE      = 2'd0,
        SLOT_CAPTURING = 2'd1,
        SLOT_READY     = 2'd2
    } slot_state_t;

    // A selector or index never collapses to zero bits, even for a single entry.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int col_width(input int columns);
        return min1_clog2(columns);
    endfunction

    function automatic int line_width(input int lines);
        return min1_clog2(lines);
    endfunction

    function automatic int slot_sel_width(input int slots);
        return min1_clog2(slots);
    endfunction

    function automatic int sum_width(input int data_width, input int columns);
        return data_width + $clog2(columns) + 1;
    endfunction

endpackage

// File: rtl/multi_line_buffer_if.sv
// Pixel-stream, read and flag signals of the multi-slot line buffer.
// LINE_SUMS exists only when MULTI_LINE_BUFFER_LINE_SUM_EN is defined.
interface multi_line_buffer_if #(
    parameter int COLUMNS    = 752,
    parameter int LINES      = 480,
    parameter int DATA_WIDTH = 10,
    parameter int SLOTS      = 4
) ();
    import multi_line_buffer_pkg::*;

    localparam int CW    = col_width(COLUMNS);
    localparam int LW    = line_width(LINES);
    localparam int SEL_W = slot_sel_width(SLOTS);
    localparam int SW    = sum_width(DATA_WIDTH, COLUMNS);

    logic                  VALID_DATA;
    logic [CW-1:0]         CURRENT_COLUMN;
    logic [LW-1:0]         CURRENT_LINE;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [SLOTS*LW-1:0]   INTERESTING_LINES;
    logic [SEL_W-1:0]      READ_SLOT;
    logic [CW-1:0]         READ_ADDRESS;
    logic [SLOTS-1:0]      RESET_READY_FLAGS;
    logic [SLOTS-1:0]      WHOLE_LINE_READY_FLAGS;
    logic [SLOTS-1:0]      MISSED_FLAGS;
    logic [DATA_WIDTH-1:0] DATA_OUT;
`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
    logic [SLOTS*SW-1:0]   LINE_SUMS;
`endif

    modport master (
        output VALID_DATA, CURRENT_COLUMN, CURRENT_LINE, DATA_IN, INTERESTING_LINES,
        output READ_SLOT, READ_ADDRESS, RESET_READY_FLAGS,
`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
        input  LINE_SUMS,
`endif
        input  WHOLE_LINE_READY_FLAGS, MISSED_FLAGS, DATA_OUT
    );

    modport slave (
        input  VALID_DATA, CURRENT_COLUMN, CURRENT_LINE, DATA_IN, INTERESTING_LINES,
        input  READ_SLOT, READ_ADDRESS, RESET_READY_FLAGS,
`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
        output LINE_SUMS,
`endif
        output WHOLE_LINE_READY_FLAGS, MISSED_FLAGS, DATA_OUT
    );

endinterface

// File: rtl/multi_line_buffer_slot.sv
// One capture slot: IDLE/CAPTURING/READY state machine, line bank with async read, flags.
// MULTI_LINE_BUFFER_LINE_SUM_EN adds a running sum of the captured pixels.
module multi_line_buffer_slot
    import multi_line_buffer_pkg::*;
#(
    parameter int  COLUMNS    = 752,
    parameter int  LINES      = 480,
    parameter int  DATA_WIDTH = 10,
    localparam int CW         = col_width(COLUMNS),
    localparam int LW         = line_width(LINES),
    localparam int SW         = sum_width(DATA_WIDTH, COLUMNS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid_data,
    input  logic [CW-1:0]         current_column,
    input  logic [LW-1:0]         current_line,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LW-1:0]         interesting_line,
    input  logic                  clear,
    input  logic [CW-1:0]         read_address,
    output logic [DATA_WIDTH-1:0] read_data,
`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
    output logic [SW-1:0]         line_sum,
`endif
    output logic                  ready,
    output logic                  missed
);

    localparam logic [CW:0]   COL_LIMIT = (CW+1)'(COLUMNS);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLUMNS - 1);

    slot_state_t           state, state_nxt;
    logic                  match, at_col0, at_last, in_range;
    logic                  wr_en, miss_hit;
    logic [DATA_WIDTH-1:0] bank [COLUMNS];

    assign match    = valid_data && (current_line == interesting_line);
    assign at_col0  = (current_column == '0);
    assign at_last  = (current_column == LAST_COL);
    assign in_range = ({1'b0, current_column} < COL_LIMIT);

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        miss_hit  = 1'b0;
        case (state)
            SLOT_IDLE: begin
                // Only a line seen from its first pixel is worth capturing.
                if (match && at_col0) begin
                    wr_en     = 1'b1;
                    state_nxt = (COLUMNS == 1) ? SLOT_READY : SLOT_CAPTURING;
                end
            end
            SLOT_CAPTURING: begin
                if (match) begin
                    if (in_range) begin
                        wr_en = 1'b1;
                        if (at_last) state_nxt = SLOT_READY;
                    end
                end else if (valid_data) begin
                    state_nxt = SLOT_IDLE;
                end
            end
            SLOT_READY: begin
                if (clear)                  state_nxt = SLOT_IDLE;
                else if (match && at_col0)  miss_hit  = 1'b1;
            end
            default: state_nxt = SLOT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= SLOT_IDLE;
            missed <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == SLOT_READY && clear) missed <= 1'b0;
            else if (miss_hit)                missed <= 1'b1;
        end
    end

    // Bank contents survive reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) bank[current_column] <= data_in;
    end

    assign ready     = (state == SLOT_READY);
    assign read_data = ({1'b0, read_address} < COL_LIMIT) ? bank[read_address] : '0;

`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
    logic [SW-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (!reset_n)     sum_q <= '0;
        else if (wr_en)   sum_q <= at_col0 ? SW'(data_in) : sum_q + SW'(data_in);
    end

    assign line_sum = sum_q;
`endif

endmodule

// File: rtl/multi_line_buffer.sv
// Multi-slot camera line capture buffer: SLOTS independent capture slots and a registered read mux.
// MULTI_LINE_BUFFER_LINE_SUM_EN adds per-slot LINE_SUMS on the interface.
module multi_line_buffer
    import multi_line_buffer_pkg::*;
#(
    parameter int COLUMNS    = 752,
    parameter int LINES      = 480,
    parameter int DATA_WIDTH = 10,
    parameter int SLOTS      = 4
) (
    input logic              CLK,
    input logic              RESET_N,
    multi_line_buffer_if.slave bus
);

    localparam int LW    = line_width(LINES);
    localparam int SEL_W = slot_sel_width(SLOTS);
    localparam logic [SEL_W:0] SLOT_LIMIT = (SEL_W+1)'(SLOTS);
`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
    localparam int SW    = sum_width(DATA_WIDTH, COLUMNS);
    logic [SLOTS*SW-1:0]   sums;
`endif

    logic [DATA_WIDTH-1:0] slot_data [SLOTS];
    logic [SLOTS-1:0]      ready, missed;
    logic [DATA_WIDTH-1:0] data_q;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        multi_line_buffer_slot #(
            .COLUMNS    (COLUMNS),
            .LINES      (LINES),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk              (CLK),
            .reset_n          (RESET_N),
            .valid_data       (bus.VALID_DATA),
            .current_column   (bus.CURRENT_COLUMN),
            .current_line     (bus.CURRENT_LINE),
            .data_in          (bus.DATA_IN),
            .interesting_line (bus.INTERESTING_LINES[i*LW +: LW]),
            .clear            (bus.RESET_READY_FLAGS[i]),
            .read_address     (bus.READ_ADDRESS),
            .read_data        (slot_data[i]),
`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
            .line_sum         (sums[i*SW +: SW]),
`endif
            .ready            (ready[i]),
            .missed           (missed[i])
        );
    end

    // Registered read: one cycle from address to DATA_OUT.
    always_ff @(posedge CLK) begin
        if (!RESET_N)
            data_q <= '0;
        else if ({1'b0, bus.READ_SLOT} < SLOT_LIMIT)
            data_q <= slot_data[bus.READ_SLOT];
        else
            data_q <= '0;
    end

    assign bus.WHOLE_LINE_READY_FLAGS = ready;
    assign bus.MISSED_FLAGS           = missed;
    assign bus.DATA_OUT               = data_q;
`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
    assign bus.LINE_SUMS              = sums;
`endif

endmodule

// File: tb/tb_multi_line_buffer.sv
// Directed bench for multi_line_buffer: 2 columns, 3 lines, 2 slots watching lines 1 and 2.
// Line-sum checks are included when MULTI_LINE_BUFFER_LINE_SUM_EN is defined.
module tb_multi_line_buffer;

    localparam int COLUMNS = 2;
    localparam int LINES   = 3;
    localparam int DW      = 10;
    localparam int SLOTS   = 2;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    multi_line_buffer_if #(.COLUMNS(COLUMNS), .LINES(LINES), .DATA_WIDTH(DW), .SLOTS(SLOTS)) bus ();

    multi_line_buffer #(.COLUMNS(COLUMNS), .LINES(LINES), .DATA_WIDTH(DW), .SLOTS(SLOTS)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        logic          v;
        logic [1:0]    ln;
        logic          col;
        logic [DW-1:0] d;
        logic [1:0]    clr;
        logic          rs;
        logic          ra;
        logic [1:0]    er;
        logic [1:0]    em;
        logic          cd;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] ln, input logic col, input logic [DW-1:0] d,
                         input logic [1:0] clr, input logic rs, input logic ra);
        bus.VALID_DATA        = v;
        bus.CURRENT_LINE      = ln;
        bus.CURRENT_COLUMN    = col;
        bus.DATA_IN           = d;
        bus.RESET_READY_FLAGS = clr;
        bus.READ_SLOT         = rs;
        bus.READ_ADDRESS      = ra;
        tick();
    endtask

    task automatic add(input logic v, input logic [1:0] ln, input logic col, input logic [DW-1:0] d,
                       input logic [1:0] clr, input logic rs, input logic ra,
                       input logic [1:0] er, input logic [1:0] em, input logic cd, input logic [DW-1:0] ed);
        vecs.push_back('{v, ln, col, d, clr, rs, ra, er, em, cd, ed});
    endtask

`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
    task automatic chk_sums(input string tag, input int s0, input int s1);
        logic [23:0] sums;
        sums = bus.LINE_SUMS;
        chk({tag, " sum0"}, 32'(sums[11:0]), s0);
        chk({tag, " sum1"}, 32'(sums[23:12]), s1);
    endtask
`endif

    initial begin
        bus.INTERESTING_LINES = {2'd2, 2'd1};
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("reset ready", 32'(bus.WHOLE_LINE_READY_FLAGS), 0);
        chk("reset missed", 32'(bus.MISSED_FLAGS), 0);
        chk("reset dout", 32'(bus.DATA_OUT), 0);
`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
        chk_sums("reset", 0, 0);
`endif
        RESET_N = 1'b1;

        // Stream joins mid-line: slot0 must ignore the tail of line 1.
        drive(1, 1, 1, 21, 0, 0, 0);
        chk("midframe ready a", 32'(bus.WHOLE_LINE_READY_FLAGS), 0);
        drive(1, 2, 0, 31, 0, 0, 0);
        drive(1, 2, 1, 32, 0, 0, 0);
        chk("midframe ready b", 32'(bus.WHOLE_LINE_READY_FLAGS), 2);
        drive(0, 0, 0, 0, 2'b11, 0, 0);
        chk("midframe clear", 32'(bus.WHOLE_LINE_READY_FLAGS), 0);

        // Frame 1: both slots capture.
        add(1,0,0,11, 0,0,0, 0,0,0,0);
        add(1,0,1,12, 0,0,0, 0,0,0,0);
        add(1,1,0,21, 0,0,0, 0,0,0,0);
        add(1,1,1,22, 0,0,0, 1,0,0,0);
        add(1,2,0,31, 0,0,0, 1,0,0,0);
        add(1,2,1,32, 0,0,0, 3,0,0,0);
        add(0,0,0,0,  0,0,0, 3,0,1,21);
        add(0,0,0,0,  0,0,1, 3,0,1,22);
        add(0,0,0,0,  0,1,0, 3,0,1,31);
        add(0,0,0,0,  0,1,1, 3,0,1,32);
        // Frame 2 without clearing: misses, banks frozen.
        add(1,0,0,11, 0,0,0, 3,0,0,0);
        add(1,0,1,12, 0,0,0, 3,0,0,0);
        add(1,1,0,41, 0,0,0, 3,1,0,0);
        add(1,1,1,42, 0,0,0, 3,1,0,0);
        add(1,2,0,51, 0,0,0, 3,3,0,0);
        add(1,2,1,52, 0,0,0, 3,3,0,0);
        add(0,0,0,0,  0,0,0, 3,3,1,21);
        add(0,0,0,0,  0,0,1, 3,3,1,22);
        add(0,0,0,0,  1,0,0, 2,2,0,0);
        add(0,0,0,0,  2,0,0, 0,0,0,0);
        // Frame 3: recapture; clear on slot1's last write loses to completion.
        add(1,0,0,11, 0,0,0, 0,0,0,0);
        add(1,0,1,12, 0,0,0, 0,0,0,0);
        add(1,1,0,61, 0,0,0, 0,0,0,0);
        add(1,1,1,62, 0,0,0, 1,0,0,0);
        add(1,2,0,71, 0,0,0, 1,0,0,0);
        add(1,2,1,72, 2,0,0, 3,0,0,0);
        add(0,0,0,0,  0,0,0, 3,0,1,61);
        add(0,0,0,0,  0,0,1, 3,0,1,62);
        add(0,0,0,0,  0,1,0, 3,0,1,71);
        add(0,0,0,0,  0,1,1, 3,0,1,72);
        add(0,0,0,0,  3,0,0, 0,0,0,0);
        // Line 1 cut short by line 2: slot0 aborts.
        add(1,1,0,81, 0,0,0, 0,0,0,0);
        add(0,0,0,0,  0,0,0, 0,0,0,0);
        add(1,2,0,91, 0,0,0, 0,0,0,0);
        add(1,2,1,92, 0,0,0, 2,0,0,0);
        add(1,1,1,82, 0,0,0, 2,0,0,0);
        add(0,0,0,0,  0,1,0, 2,0,1,91);
        add(0,0,0,0,  0,1,1, 2,0,1,92);
        add(0,0,0,0,  3,0,0, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].ln, vecs[i].col, vecs[i].d, vecs[i].clr, vecs[i].rs, vecs[i].ra);
            chk($sformatf("vec%0d ready", i), 32'(bus.WHOLE_LINE_READY_FLAGS), 32'(vecs[i].er));
            chk($sformatf("vec%0d missed", i), 32'(bus.MISSED_FLAGS), 32'(vecs[i].em));
            if (vecs[i].cd)
                chk($sformatf("vec%0d dout", i), 32'(bus.DATA_OUT), 32'(vecs[i].ed));
`ifdef MULTI_LINE_BUFFER_LINE_SUM_EN
            if (i == 9)  chk_sums("frame1", 43, 63);
            if (i == 19) chk_sums("cleared", 43, 63);
            if (i == 29) chk_sums("frame3", 123, 143);
`endif
        end

        // Reset in the middle of a capture, with flags and DATA_OUT nonzero.
        drive(1, 2, 0, 7, 0, 0, 0);
        drive(1, 2, 1, 8, 0, 0, 0);
        chk("prereset ready", 32'(bus.WHOLE_LINE_READY_FLAGS), 2);
        drive(1, 2, 0, 10, 0, 1, 0);
        chk("prereset missed", 32'(bus.MISSED_FLAGS), 2);
        chk("prereset dout a", 32'(bus.DATA_OUT), 7);
        drive(1, 1, 0, 9, 0, 1, 1);
        chk("prereset dout b", 32'(bus.DATA_OUT), 8);
        RESET_N = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("midreset ready", 32'(bus.WHOLE_LINE_READY_FLAGS), 0);
        chk("midreset missed", 32'(bus.MISSED_FLAGS), 0);
        chk("midreset dout", 32'(bus.DATA_OUT), 0);
        RESET_N = 1'b1;
        drive(1, 1, 1, 5, 0, 0, 0);
        chk("partial discarded", 32'(bus.WHOLE_LINE_READY_FLAGS), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_line_buffer.md
Name: multi_line_buffer

Overview:
- Successor to the single-line capture buffer. Captures up to SLOTS independently selected camera lines per frame into separate banks.
- Each slot has its own ready and missed flag and its own clear.
- Sits between the camera pixel stream (pixel valid, line and column indices, data) and downstream line consumers.
- A consumer reads a captured line by slot and address.

Parameters:
- COLUMNS, 752, pixels per line.
- LINES, 480, lines per frame.
- DATA_WIDTH, 10, pixel width.
- SLOTS, 4, number of independent line slots (1..8).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- VALID_DATA  in  1  pixel strobe from camera.
- CURRENT_COLUMN  in  CW=clog2(COLUMNS)  column of current pixel.
- CURRENT_LINE  in  LW=clog2(LINES)  line of current pixel.
- DATA_IN  in  DATA_WIDTH  pixel data.
- INTERESTING_LINES  in  SLOTS*LW  line number per slot; slot i uses bits [i*LW +: LW].
- READ_SLOT  in  clog2(SLOTS) (min 1)  slot to read.
- READ_ADDRESS  in  CW  column to read.
- RESET_READY_FLAGS  in  SLOTS  per-slot clear of READY and MISSED.
- WHOLE_LINE_READY_FLAGS  out  SLOTS  slot i holds a complete line.
- MISSED_FLAGS  out  SLOTS  sticky: a matching line arrived while slot i was READY.
- DATA_OUT  out  DATA_WIDTH  read data.

Behaviour:
- Reset (RESET_N=0 at an edge): all slots go to IDLE; WHOLE_LINE_READY_FLAGS=0, MISSED_FLAGS=0, DATA_OUT=0. Bank contents are not cleared. Reset mid-capture discards the partial line.
- Per-slot FSM, states IDLE, CAPTURING, READY. Define match_i = VALID_DATA && CURRENT_LINE==INTERESTING_LINES[i].
- IDLE:
  - match_i && CURRENT_COLUMN==0: write DATA_IN to bank i address 0.
  - If COLUMNS==1, go to READY; otherwise go to CAPTURING.
  - A match at nonzero column is ignored. This drops lines already in progress at power-up.
- CAPTURING:
  - Each match_i writes bank i at CURRENT_COLUMN.
  - A write at CURRENT_COLUMN==COLUMNS-1 goes to READY in the same cycle.
  - VALID_DATA with a non-matching line (line ended early or frame restarted) aborts to IDLE; no flag is set.
  - A match at column 0 restarts the capture (word 0 written, stay CAPTURING).
- READY:
  - Bank is frozen. No writes occur while READY.
  - match_i && CURRENT_COLUMN==0 sets MISSED_FLAGS[i].
  - RESET_READY_FLAGS[i] returns the slot to IDLE and clears MISSED_FLAGS[i]. The cleared slot may start a new capture in the next cycle, not the same one.
- WHOLE_LINE_READY_FLAGS[i] is 1 exactly in READY, registered. It rises the cycle after the last-column write.
- Simultaneous events:
  - RESET_READY_FLAGS[i] in IDLE/CAPTURING is ignored.
  - Completion and clear in the same cycle: completion wins (slot enters READY).
  - Two slots with equal INTERESTING_LINES capture the same line in parallel.
- INTERESTING_LINES is sampled every cycle. Changing it mid-capture aborts that slot at its next valid pixel.
- Read: DATA_OUT registered, 1-cycle latency: DATA_OUT(t+1) = bank[READ_SLOT][READ_ADDRESS](t).
- Out-of-range READ_SLOT or READ_ADDRESS returns 0. Reading a non-READY slot returns stale contents, undefined for verification.
- Writes use no PIXCLK crossing. Inputs are already synchronous to CLK.

Optional Feature:
- Macro MULTI_LINE_BUFFER_LINE_SUM_EN. When defined:
  - Adds output LINE_SUMS [SLOTS*SW], SW=DATA_WIDTH+clog2(COLUMNS)+1.
  - A per-slot accumulator loads DATA_IN on the column-0 write and adds each later written pixel.
  - The sum is frozen and valid while READY and holds across clear until the next capture start.
  - Reset value 0.
- When undefined, the port and accumulators are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - slot state encoding (IDLE=0, CAPTURING=1, READY=2);
  - width helper functions (clog2-based CW, LW, SW);
  - slot-select width rule (min 1 bit).
- One sub-module, multi_line_buffer_slot: FSM, bank memory (COLUMNS x DATA_WIDTH, one write port, async read into the top-level mux), flags, optional accumulator.
- Top level instantiates SLOTS copies and the registered read mux.

Test Plan:
- Use COLUMNS=2, LINES=3, SLOTS=2, INTERESTING_LINES={line 2, line 1}, with the existing camera model driving lines 11,12 / 21,22 / 31,32. Expected: READY flags go 01 after line 1 and 11 after line 2. Reading slot0 addr0/1 gives 21,22 one cycle later; slot1 gives 31,32.
- Start mid-frame (first pixel seen at column 1 of line 1): slot0 stays IDLE that frame and captures 21,22 in the next frame.
- Leave slot0 uncleared across a second frame: MISSED_FLAGS[0]=1 and data still 21,22. Pulse RESET_READY_FLAGS=01: READY[0]=0, MISSED[0]=0. The next frame recaptures.
- Assert RESET_READY_FLAGS[1] in the same cycle as slot1's last-column write: READY[1]=1 afterwards.
- Drop VALID_DATA after 21 and present line 2 (31) next: slot0 aborts, READY[0] stays 0. Deassert RESET_N mid-capture: all flags 0, DATA_OUT=0.
- With MULTI_LINE_BUFFER_LINE_SUM_EN: line 21,22 gives sum 43 on slot0; repeat without the macro and confirm identical flags and data.
